// File: rtl/echo_decodificador_sync_pkg.sv
// Shared definitions for the echo code link receiver.
// Holds the ten Johnson code words, the receiver FSM state type and the
// code-to-digit decode function. The encoder bench model reuses the same decode.
// Bit order of every code word: bit 4 = S1 .. bit 0 = S5.

package echo_decodificador_sync_pkg;

    localparam int unsigned CodeW  = 5;
    localparam int unsigned DigitW = 4;

    localparam logic [CodeW-1:0] JCode0 = 5'b11111;
    localparam logic [CodeW-1:0] JCode1 = 5'b01111;
    localparam logic [CodeW-1:0] JCode2 = 5'b00111;
    localparam logic [CodeW-1:0] JCode3 = 5'b00011;
    localparam logic [CodeW-1:0] JCode4 = 5'b00001;
    localparam logic [CodeW-1:0] JCode5 = 5'b00000;
    localparam logic [CodeW-1:0] JCode6 = 5'b10000;
    localparam logic [CodeW-1:0] JCode7 = 5'b11000;
    localparam logic [CodeW-1:0] JCode8 = 5'b11100;
    localparam logic [CodeW-1:0] JCode9 = 5'b11110;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StPresent
    } state_e;

    typedef struct packed {
        logic              legal;
        logic [DigitW-1:0] digit;
    } decode_t;

    // Illegal words decode to digit 0 so that an unused digit field never
    // carries a value outside 0-9.
    function automatic decode_t decode_jcode(input logic [CodeW-1:0] code);
        decode_t res;
        res.legal = 1'b1;
        res.digit = 4'd0;
        case (code)
            JCode0:  res.digit = 4'd0;
            JCode1:  res.digit = 4'd1;
            JCode2:  res.digit = 4'd2;
            JCode3:  res.digit = 4'd3;
            JCode4:  res.digit = 4'd4;
            JCode5:  res.digit = 4'd5;
            JCode6:  res.digit = 4'd6;
            JCode7:  res.digit = 4'd7;
            JCode8:  res.digit = 4'd8;
            JCode9:  res.digit = 4'd9;
            default: res.legal = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/echo_decodificador_sync_debounce.sv
// Two-flop synchroniser for the code word and the link qualifier, followed by
// a stability counter on the synchronised code.
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   s_i          asynchronous code word (bit 4 = S1)
//   en_i         asynchronous link qualifier
//   restart_i    clears the stability counter (code must re-settle)
//   code_sync_o  synchronised code word
//   en_sync_o    synchronised link qualifier
//   stable_o     code_sync_o unchanged for StableCycles consecutive cycles

module echo_decodificador_sync_debounce
    import echo_decodificador_sync_pkg::*;
#(
    parameter int unsigned StableCycles = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CodeW-1:0] s_i,
    input  logic             en_i,
    input  logic             restart_i,
    output logic [CodeW-1:0] code_sync_o,
    output logic             en_sync_o,
    output logic             stable_o
);

    localparam int unsigned CntW = $clog2(StableCycles + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(StableCycles);

    logic [CodeW-1:0] s_meta_q;
    logic [CodeW-1:0] s_sync_q;
    logic             en_meta_q;
    logic             en_sync_q;
    logic [CntW-1:0]  cnt_q;
    logic [CntW-1:0]  cnt_d;

    // The counter clears on the same edge a new value lands in the sync
    // stage, so it measures how long the visible code has been unchanged.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (s_meta_q != s_sync_q)) begin
            cnt_d = '0;
        end else if (cnt_q < MaxCnt) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_meta_q  <= '0;
            s_sync_q  <= '0;
            en_meta_q <= 1'b0;
            en_sync_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s_meta_q  <= s_i;
            s_sync_q  <= s_meta_q;
            en_meta_q <= en_i;
            en_sync_q <= en_meta_q;
            cnt_q     <= cnt_d;
        end
    end

    assign code_sync_o = s_sync_q;
    assign en_sync_o   = en_sync_q;
    assign stable_o    = (cnt_q == MaxCnt);

endmodule

// File: rtl/echo_decodificador_sync.sv
// Receiving end of the echo code link. Synchronises and debounces the 5-bit
// Johnson code, decodes it to a BCD digit and hands each new digit downstream
// over a valid/ready handshake. Illegal stable words pulse illegal_o and bump a
// saturating error counter.
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   en_i         link qualifier, asynchronous
//   s_i          code word, bit 4 = S1 .. bit 0 = S5, asynchronous
//   out_ready_i  downstream accepts the digit
//   out_valid_o  out_digit_o holds a new digit
//   out_digit_o  decoded BCD digit 0-9
//   illegal_o    one-cycle pulse: stable code not in the table
//   err_count_o  saturating count of illegal_o pulses

module echo_decodificador_sync
    import echo_decodificador_sync_pkg::*;
#(
    parameter int unsigned StableCycles = 4,
    parameter int unsigned ErrCntW      = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic [CodeW-1:0]   s_i,
    input  logic               out_ready_i,
    output logic               out_valid_o,
    output logic [DigitW-1:0]  out_digit_o,
    output logic               illegal_o,
    output logic [ErrCntW-1:0] err_count_o
);

    logic [CodeW-1:0]   code_sync;
    logic               en_sync;
    logic               stable;
    logic               restart;
    decode_t            dec;

    state_e             state_q,      state_d;
    logic [CodeW-1:0]   last_code_q,  last_code_d;
    logic               last_valid_q, last_valid_d;
    logic               out_valid_q,  out_valid_d;
    logic [DigitW-1:0]  out_digit_q,  out_digit_d;
    logic               illegal_q,    illegal_d;
    logic [ErrCntW-1:0] err_cnt_q,    err_cnt_d;

    echo_decodificador_sync_debounce #(
        .StableCycles (StableCycles)
    ) u_sync_debounce (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_i         (s_i),
        .en_i        (en_i),
        .restart_i   (restart),
        .code_sync_o (code_sync),
        .en_sync_o   (en_sync),
        .stable_o    (stable)
    );

    always_comb begin
        dec = decode_jcode(code_sync);
    end

    always_comb begin
        state_d      = state_q;
        last_code_d  = last_code_q;
        last_valid_d = last_valid_q;
        out_valid_d  = out_valid_q;
        out_digit_d  = out_digit_q;
        illegal_d    = 1'b0;
        err_cnt_d    = err_cnt_q;
        restart      = 1'b0;

        // A disabled link overrides everything, including a pending digit and
        // an illegal word that happens to become stable in the same cycle.
        // Forgetting last_code makes the next enable re-present the code.
        if (!en_sync) begin
            state_d      = StIdle;
            out_valid_d  = 1'b0;
            last_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StSettle;
                end
                StSettle: begin
                    if (stable && !(last_valid_q && (code_sync == last_code_q))) begin
                        last_code_d  = code_sync;
                        last_valid_d = 1'b1;
                        if (dec.legal) begin
                            out_digit_d = dec.digit;
                            out_valid_d = 1'b1;
                            state_d     = StPresent;
                        end else begin
                            illegal_d = 1'b1;
                            if (err_cnt_q != {ErrCntW{1'b1}}) begin
                                err_cnt_d = err_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                StPresent: begin
                    // Code movement while presenting is ignored; the restart
                    // forces a fresh settle before it is judged again.
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        state_d     = StSettle;
                        restart     = 1'b1;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            last_code_q  <= '0;
            last_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_digit_q  <= '0;
            illegal_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_code_q  <= last_code_d;
            last_valid_q <= last_valid_d;
            out_valid_q  <= out_valid_d;
            out_digit_q  <= out_digit_d;
            illegal_q    <= illegal_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_digit_o = out_digit_q;
    assign illegal_o   = illegal_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_echo_decodificador_sync.sv
// Directed bench for the echo code receiver. Stimulus pushes each expected
// transferred digit into a queue; a monitor on the falling edge pops and
// compares on every valid&ready cycle, checks the hold rule and counts
// illegal pulses.

module tb_echo_decodificador_sync;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       en_i = 1'b0;
    logic [4:0] s_i = 5'b00000;
    logic       out_ready_i = 1'b0;
    logic       out_valid_o;
    logic [3:0] out_digit_o;
    logic       illegal_o;
    logic [7:0] err_count_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ill_seen = 0;
    int exp_q[$];

    logic       hold_pending = 1'b0;
    logic [3:0] held_digit   = 4'd0;

    echo_decodificador_sync #(
        .StableCycles (4),
        .ErrCntW      (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .s_i         (s_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .out_digit_o (out_digit_o),
        .illegal_o   (illegal_o),
        .err_count_o (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge clk_i);
            c++;
        end
        @(negedge clk_i);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: transfers, hold rule, digit range, illegal pulses.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (illegal_o) ill_seen++;
            if (out_valid_o) begin
                check("digit in range", int'(out_digit_o <= 4'd9), 1);
                if (hold_pending) check("digit held", int'(out_digit_o), int'(held_digit));
                if (out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected transfer: got digit %0d, expected none",
                                 out_digit_o);
                    end else begin
                        check("transfer digit", int'(out_digit_o), exp_q.pop_front());
                    end
                    hold_pending = 1'b0;
                end else begin
                    hold_pending = 1'b1;
                    held_digit   = out_digit_o;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    logic [4:0] sweep_codes [10] = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                                     5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};
    int         sweep_digits[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};

    initial begin
        int ill_base;
        step(3);
        rst_ni = 1'b1;
        step(2);

        // 1: reset mid-activity, then silence while EN is low.
        en_i = 1'b1;
        s_i  = 5'b10101;
        step(8);
        check("t1 illegal pulses", ill_seen, 1);
        check("t1 err count", int'(err_count_o), 1);
        s_i = 5'b00111;
        step(10);
        check("t1 valid before reset", int'(out_valid_o), 1);
        check("t1 digit before reset", int'(out_digit_o), 2);
        #1;
        rst_ni = 1'b0;
        #1;
        check("reset valid", int'(out_valid_o), 0);
        check("reset digit", int'(out_digit_o), 0);
        check("reset illegal", int'(illegal_o), 0);
        check("reset err count", int'(err_count_o), 0);
        en_i = 1'b0;
        s_i  = 5'b00000;
        step(2);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;
        s_i         = 5'b00111;
        step(10);
        check("idle no valid", int'(out_valid_o), 0);
        s_i = 5'b00000;
        step(6);

        // 2: exact latency, EN and S=11000 together.
        exp_q.push_back(7);
        en_i = 1'b1;
        s_i  = 5'b11000;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check($sformatf("t2 valid at cycle %0d", c), int'(out_valid_o), int'(c == 6));
        end
        drain("t2 drain", 4);

        // 3: sweep all ten legal codes.
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(sweep_digits[i]);
            s_i = sweep_codes[i];
            step(12);
        end
        drain("t3 drain", 20);

        // 4: one illegal word, then saturation.
        ill_base = ill_seen;
        s_i = 5'b10101;
        step(30);
        check("t4 single pulse", ill_seen - ill_base, 1);
        check("t4 err count 1", int'(err_count_o), 1);
        for (int i = 0; i < 300; i++) begin
            s_i = (i % 2 == 0) ? 5'b01010 : 5'b10101;
            step(8);
        end
        check("t4 pulses after alternation", ill_seen - ill_base, 301);
        check("t4 err saturated", int'(err_count_o), 255);

        // 5: chatter never settles, then a steady 3.
        ill_base = ill_seen;
        for (int i = 0; i < 20; i++) begin
            s_i = (i % 2 == 0) ? 5'b00111 : 5'b00011;
            step(2);
        end
        check("t5 no illegal", ill_seen - ill_base, 0);
        check("t5 no valid", int'(out_valid_o), 0);
        exp_q.push_back(3);
        s_i = 5'b00011;
        step(12);
        drain("t5 drain", 20);

        // 6: backpressure hold, then EN drop while presenting.
        out_ready_i = 1'b0;
        s_i = 5'b00111;
        step(10);
        check("t6 valid presenting", int'(out_valid_o), 1);
        check("t6 digit 2", int'(out_digit_o), 2);
        s_i = 5'b00001;
        step(10);
        check("t6 still valid", int'(out_valid_o), 1);
        check("t6 still 2", int'(out_digit_o), 2);
        exp_q.push_back(2);
        exp_q.push_back(4);
        out_ready_i = 1'b1;
        step(14);
        drain("t6 drain", 20);

        out_ready_i = 1'b0;
        s_i = 5'b00111;
        step(10);
        check("t6b valid presenting", int'(out_valid_o), 1);
        en_i = 1'b0;
        step(3);
        check("t6b valid dropped", int'(out_valid_o), 0);
        out_ready_i = 1'b1;
        step(5);
        check("t6b still low", int'(out_valid_o), 0);
        exp_q.push_back(2);
        en_i = 1'b1;
        step(12);
        drain("t6b re-present", 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
